// File: rtl/dout_arbiter.sv
`timescale 1ns/1ps
// dout_arbiter: arbitrates ADD/MUL/SHIFT results onto one tagged 48-bit output FIFO write port.
// Latency: ack in the cycle a req is seen in IDLE, first word on the next cycle; GAP_CYCLES idle cycles after each packet.
// Backpressure: fifo_full holds the current word and index (wren=0, dataout=0); no word is lost or repeated.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   {add,mul,shf}_req/_sel/_result   pending result, sel tag and payload (held until ack)
//   {add,mul,shf}_ack                one-cycle pulse when the result is captured
//   fifo_full                        output FIFO cannot take a word this cycle
//   dataout, wren                    {app, 1'b0, sel, idx, 40-bit slice} and its write strobe
//   busy, pkt_done                   packet in progress / last word of a packet
module dout_arbiter #(
  parameter bit RR_EN      = 1'b1,
  parameter int GAP_CYCLES = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         add_req,
  input  logic         add_sel,
  input  logic [79:0]  add_result,
  output logic         add_ack,
  input  logic         mul_req,
  input  logic         mul_sel,
  input  logic [159:0] mul_result,
  output logic         mul_ack,
  input  logic         shf_req,
  input  logic         shf_sel,
  input  logic [79:0]  shf_result,
  output logic         shf_ack,
  input  logic         fifo_full,
  output logic [47:0]  dataout,
  output logic         wren,
  output logic         busy,
  output logic         pkt_done
);

  localparam logic [2:0] APP_ADD = 3'b001;
  localparam logic [2:0] APP_MUL = 3'b010;
  localparam logic [2:0] APP_SHF = 3'b011;
  localparam logic [1:0] U_ADD   = 2'd0;
  localparam logic [1:0] U_MUL   = 2'd1;
  localparam logic [1:0] U_SHF   = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

  state_t       state_q, state_d;
  logic [159:0] hold_q, hold_d;
  logic [2:0]   app_q, app_d;
  logic [2:0]   idx_q, idx_d;
  logic [2:0]   gap_q, gap_d;
  logic         sel_q, sel_d;
  logic         mul_q, mul_d;
  logic [1:0]   last_q, last_d;

  // Arbitration: build a search order starting after the last grant
  // (or fixed ADD > MUL > SHIFT), then take the first requester in it.
  logic [3:0] req_v;
  logic [1:0] ord0, ord1, ord2, win;
  logic       win_vld;

  assign req_v = {1'b0, shf_req, mul_req, add_req};

  always_comb begin
    ord0 = U_ADD;
    ord1 = U_MUL;
    ord2 = U_SHF;
    if (RR_EN) begin
      case (last_q)
        U_ADD:   begin ord0 = U_MUL; ord1 = U_SHF; ord2 = U_ADD; end
        U_MUL:   begin ord0 = U_SHF; ord1 = U_ADD; ord2 = U_MUL; end
        default: begin ord0 = U_ADD; ord1 = U_MUL; ord2 = U_SHF; end
      endcase
    end
    win_vld = |req_v;
    if (req_v[ord0])      win = ord0;
    else if (req_v[ord1]) win = ord1;
    else                  win = ord2;
  end

  // Word slicing: 80-bit results sit zero-extended in the low half of the
  // holding register, so ADD/SHIFT idx 0/1 map to 40-bit chunks 2/3 while
  // MUL idx 1..4 map to chunks 0..3 (chunk 0 = bits 159:120).
  logic [1:0]  chunk;
  logic [39:0] slice;
  logic        last_word;

  always_comb begin
    chunk = mul_q ? 2'(idx_q - 3'd1) : 2'(idx_q + 3'd2);
    case (chunk)
      2'd0:    slice = hold_q[159:120];
      2'd1:    slice = hold_q[119:80];
      2'd2:    slice = hold_q[79:40];
      default: slice = hold_q[39:0];
    endcase
    last_word = mul_q ? (idx_q == 3'd4) : (idx_q == 3'd1);
  end

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    app_d    = app_q;
    idx_d    = idx_q;
    gap_d    = gap_q;
    sel_d    = sel_q;
    mul_d    = mul_q;
    last_d   = last_q;
    add_ack  = 1'b0;
    mul_ack  = 1'b0;
    shf_ack  = 1'b0;
    wren     = 1'b0;
    dataout  = '0;
    pkt_done = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Acks are combinational on req; gating with rst_n keeps them low
        // while reset is held even though the state already reads IDLE.
        if (win_vld && rst_n) begin
          last_d  = win;
          state_d = S_SEND;
          case (win)
            U_ADD: begin
              add_ack = 1'b1;
              app_d   = APP_ADD;
              sel_d   = add_sel;
              hold_d  = {80'd0, add_result};
              mul_d   = 1'b0;
              idx_d   = 3'd0;
            end
            U_MUL: begin
              mul_ack = 1'b1;
              app_d   = APP_MUL;
              sel_d   = mul_sel;
              hold_d  = mul_result;
              mul_d   = 1'b1;
              idx_d   = 3'd1;
            end
            default: begin
              shf_ack = 1'b1;
              app_d   = APP_SHF;
              sel_d   = shf_sel;
              hold_d  = {80'd0, shf_result};
              mul_d   = 1'b0;
              idx_d   = 3'd0;
            end
          endcase
        end
      end
      S_SEND: begin
        if (!fifo_full) begin
          wren    = 1'b1;
          dataout = {app_q, 1'b0, sel_q, idx_q, slice};
          idx_d   = idx_q + 3'd1;
          if (last_word) begin
            pkt_done = 1'b1;
            gap_d    = '0;
            state_d  = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
          end
        end
      end
      S_GAP: begin
        if (int'(gap_q) >= GAP_CYCLES - 1) state_d = S_IDLE;
        else                               gap_d   = gap_q + 3'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy = (state_q != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      hold_q  <= '0;
      app_q   <= '0;
      idx_q   <= '0;
      gap_q   <= '0;
      sel_q   <= 1'b0;
      mul_q   <= 1'b0;
      last_q  <= U_SHF;  // so ADD is searched first after reset
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      app_q   <= app_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      sel_q   <= sel_d;
      mul_q   <= mul_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_dout_arbiter.sv
`timescale 1ns/1ps
module tb_dout_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n = 1'b0;
  logic         add_req = 1'b0, add_sel = 1'b0;
  logic         mul_req = 1'b0, mul_sel = 1'b0;
  logic         shf_req = 1'b0, shf_sel = 1'b0;
  logic         fifo_full = 1'b0;
  logic [79:0]  add_result = '0, shf_result = '0;
  logic [159:0] mul_result = '0;

  // Instance 0: RR_EN=1 GAP=1; instance 1: RR_EN=0 GAP=1; instance 2: RR_EN=1 GAP=0.
  logic        add_ack [3];
  logic        mul_ack [3];
  logic        shf_ack [3];
  logic        wren    [3];
  logic        busy    [3];
  logic        pkt_done[3];
  logic [47:0] dataout [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dout_arbiter #(.RR_EN(g != 1), .GAP_CYCLES((g == 2) ? 0 : 1)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .add_req(add_req), .add_sel(add_sel), .add_result(add_result), .add_ack(add_ack[g]),
      .mul_req(mul_req), .mul_sel(mul_sel), .mul_result(mul_result), .mul_ack(mul_ack[g]),
      .shf_req(shf_req), .shf_sel(shf_sel), .shf_result(shf_result), .shf_ack(shf_ack[g]),
      .fifo_full(fifo_full), .dataout(dataout[g]), .wren(wren[g]),
      .busy(busy[g]), .pkt_done(pkt_done[g])
    );
  end

  typedef struct packed {
    logic        aa, ma, sa, wr, bz, pd;
    logic [47:0] d;
  } obs_t;

  typedef struct {
    logic        add_req, mul_req, full;
    logic        aa, ma, wr, pd, bz;
    logic [47:0] d;
  } vec_t;

  int checks = 0;
  int failures = 0;
  int di = 0;

  // Reference model: pending words of the current packet as a queue,
  // remaining gap cycles, and the unit granted last.
  logic [47:0] mq[$];
  int m_gap, m_last, m_gapcfg;
  bit m_rr;

  function automatic obs_t get_obs();
    obs_t o;
    o.aa = add_ack[di]; o.ma = mul_ack[di]; o.sa = shf_ack[di];
    o.wr = wren[di];    o.bz = busy[di];    o.pd = pkt_done[di];
    o.d  = dataout[di];
    return o;
  endfunction

  task automatic chk_obs(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t: got ack=%b%b%b wren=%b busy=%b done=%b data=%h, want ack=%b%b%b wren=%b busy=%b done=%b data=%h",
               name, $time, act.aa, act.ma, act.sa, act.wr, act.bz, act.pd, act.d,
               exp.aa, exp.ma, exp.sa, exp.wr, exp.bz, exp.pd, exp.d);
    end
  endtask

  task automatic chk_int(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic model_reset(input int d);
    mq.delete();
    m_gap    = 0;
    m_last   = 2;
    m_rr     = (d != 1);
    m_gapcfg = (d == 2) ? 0 : 1;
  endtask

  task automatic m_push(input logic [2:0] app, input logic sel, input logic [159:0] r, input bit is_mul);
    int n;
    logic [159:0] t;
    n = is_mul ? 4 : 2;
    for (int i = 0; i < n; i++) begin
      t = r >> (40 * (n - 1 - i));
      mq.push_back({app, 1'b0, sel, 3'(is_mul ? i + 1 : i), t[39:0]});
    end
  endtask

  task automatic model_step(output obs_t e);
    int w;
    int u;
    logic [2:0] reqs;
    e = '0;
    reqs = {shf_req, mul_req, add_req};
    if (mq.size() > 0) begin
      e.bz = 1'b1;
      if (!fifo_full) begin
        e.wr = 1'b1;
        e.d  = mq.pop_front();
        if (mq.size() == 0) begin
          e.pd  = 1'b1;
          m_gap = m_gapcfg;
        end
      end
    end else if (m_gap > 0) begin
      e.bz = 1'b1;
      m_gap--;
    end else begin
      w = -1;
      for (int k = 1; k <= 3; k++) begin
        u = m_rr ? (m_last + k) % 3 : k - 1;
        if (w < 0 && reqs[u]) w = u;
      end
      if (w >= 0) begin
        m_last = w;
        case (w)
          0: begin e.aa = 1'b1; m_push(3'b001, add_sel, {80'd0, add_result}, 1'b0); end
          1: begin e.ma = 1'b1; m_push(3'b010, mul_sel, mul_result, 1'b1); end
          default: begin e.sa = 1'b1; m_push(3'b011, shf_sel, {80'd0, shf_result}, 1'b0); end
        endcase
      end
    end
  endtask

  // One clock: compare at the falling edge, return the observed outputs,
  // leave time at posedge+1 for the caller to drive the next inputs.
  task automatic step(input string tag, output obs_t a);
    obs_t e;
    @(negedge clk);
    model_step(e);
    a = get_obs();
    chk_obs(tag, a, e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int d);
    obs_t z;
    di = d;
    add_req = 0; mul_req = 0; shf_req = 0; fifo_full = 0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    z = '0;
    chk_obs("reset_outputs", get_obs(), z);
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset(d);
  endtask

  task automatic new_add();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    add_result = t[79:0]; add_sel = t[80]; add_req = 1'b1;
  endtask

  task automatic new_mul();
    logic [191:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    mul_result = t[159:0]; mul_sel = t[160]; mul_req = 1'b1;
  endtask

  task automatic new_shf();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    shf_result = t[79:0]; shf_sel = t[80]; shf_req = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[15];
    obs_t a, e;
    int   wcnt, acnt, ocnt, scnt;
    logic [5:0]  order;
    logic [31:0] ack_bm, pd_bm, wr_bm;

    // Single ADD (sel=1), then a MUL (sel=0) stalled for 3 cycles after word 2.
    tbl[0]  = '{1, 0, 0,  1, 0, 0, 0, 0, 48'h0};
    tbl[1]  = '{0, 0, 0,  0, 0, 1, 0, 1, 48'h2800_0000_0001};
    tbl[2]  = '{0, 0, 0,  0, 0, 1, 1, 1, 48'h2900_0000_0002};
    tbl[3]  = '{0, 0, 0,  0, 0, 0, 0, 1, 48'h0};
    tbl[4]  = '{0, 0, 0,  0, 0, 0, 0, 0, 48'h0};
    tbl[5]  = '{0, 1, 0,  0, 1, 0, 0, 0, 48'h0};
    tbl[6]  = '{0, 0, 0,  0, 0, 1, 0, 1, 48'h41_1111111111};
    tbl[7]  = '{0, 0, 0,  0, 0, 1, 0, 1, 48'h42_2222222222};
    tbl[8]  = '{0, 0, 1,  0, 0, 0, 0, 1, 48'h0};
    tbl[9]  = '{0, 0, 1,  0, 0, 0, 0, 1, 48'h0};
    tbl[10] = '{0, 0, 1,  0, 0, 0, 0, 1, 48'h0};
    tbl[11] = '{0, 0, 0,  0, 0, 1, 0, 1, 48'h43_3333333333};
    tbl[12] = '{0, 0, 0,  0, 0, 1, 1, 1, 48'h44_4444444444};
    tbl[13] = '{0, 0, 0,  0, 0, 0, 0, 1, 48'h0};
    tbl[14] = '{0, 0, 0,  0, 0, 0, 0, 0, 48'h0};

    // ---------------- table-driven vectors ----------------
    do_reset(0);
    add_result = 80'h0000000001_0000000002; add_sel = 1'b1;
    mul_result = {40'h1111111111, 40'h2222222222, 40'h3333333333, 40'h4444444444};
    mul_sel = 1'b0;
    wcnt = 0;
    for (int i = 0; i < 15; i++) begin
      add_req   = tbl[i].add_req;
      mul_req   = tbl[i].mul_req;
      fifo_full = tbl[i].full;
      @(negedge clk);
      e = '0;
      e.aa = tbl[i].aa; e.ma = tbl[i].ma; e.wr = tbl[i].wr;
      e.pd = tbl[i].pd; e.bz = tbl[i].bz; e.d  = tbl[i].d;
      a = get_obs();
      chk_obs($sformatf("vec%0d", i), a, e);
      if (i >= 5 && a.wr) wcnt++;
      @(posedge clk);
      #1;
    end
    chk_int("mul_stall_wren_count", wcnt, 4);

    // ---------------- round robin, all three requesting ----------------
    do_reset(0);
    new_add(); new_mul(); new_shf();
    order = '1;
    scnt = 0;
    for (int c = 0; c < 16; c++) begin
      step("rr_three", a);
      if (a.aa || a.ma || a.sa) begin
        order = {order[3:0], (a.aa ? 2'd0 : a.ma ? 2'd1 : 2'd2)};
        scnt++;
      end
      if (a.aa) add_req = 0;
      if (a.ma) mul_req = 0;
      if (a.sa) shf_req = 0;
    end
    chk_int("rr_grant_order", {26'd0, order}, 6'b00_01_10);
    chk_int("rr_grant_count", scnt, 3);

    // ---------------- fixed priority: ADD re-requests and starves others ----
    do_reset(1);
    new_add(); new_mul(); new_shf();
    acnt = 0; ocnt = 0;
    for (int c = 0; c < 30; c++) begin
      step("fixed_starve", a);
      if (a.aa) begin acnt++; new_add(); end
      if (a.ma || a.sa) ocnt++;
    end
    chk_int("fixed_add_grants", acnt, 8);
    chk_int("fixed_other_grants", ocnt, 0);

    // ---------------- reset in the middle of a MUL packet ----------------
    do_reset(0);
    new_mul();
    step("midrst_grant", a);
    mul_req = 0;
    step("midrst_w1", a);
    step("midrst_w2", a);
    new_shf();
    #1 rst_n = 1'b0;
    #1;
    e = '0;
    chk_obs("midrst_outputs_zero", get_obs(), e);
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset(0);
    scnt = 0; wcnt = 0;
    for (int c = 0; c < 5; c++) begin
      step("midrst_shf", a);
      if (a.sa) begin scnt++; shf_req = 0; end
      if (a.wr) wcnt++;
    end
    chk_int("midrst_shf_acks", scnt, 1);
    chk_int("midrst_shf_words", wcnt, 2);

    // ---------------- GAP_CYCLES=0, back-to-back ADD ----------------
    do_reset(2);
    new_add();
    ack_bm = '0; pd_bm = '0; wr_bm = '0;
    for (int c = 0; c < 12; c++) begin
      step("gap0", a);
      if (a.aa) begin ack_bm[c] = 1'b1; new_add(); end
      if (a.pd) pd_bm[c] = 1'b1;
      if (a.wr) wr_bm[c] = 1'b1;
    end
    chk_int("gap0_ack_cycles", ack_bm, 32'h249);
    chk_int("gap0_done_cycles", pd_bm, 32'h924);
    chk_int("gap0_wren_cycles", wr_bm, 32'hDB6);

    // ---------------- randomized against the reference model ----------------
    for (int d = 0; d < 3; d++) begin
      do_reset(d);
      for (int c = 0; c < 400; c++) begin
        fifo_full = ($urandom_range(0, 3) == 0);
        step("random", a);
        if (a.aa) add_req = 0;
        if (a.ma) mul_req = 0;
        if (a.sa) shf_req = 0;
        if (!add_req && $urandom_range(0, 2) == 0) new_add();
        if (!mul_req && $urandom_range(0, 2) == 0) new_mul();
        if (!shf_req && $urandom_range(0, 2) == 0) new_shf();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
